// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cond_unit
//  Brief    : Registered ARM condition unit. Holds the NZCV flag register,
//             evaluates the condition field against it, gates the decoder
//             write enables and updates the flags per group (N/Z and C/V).
//             Supports stall, flush, explicit flag load and an optional
//             registered output stage (PIPE_OUT).
//             Optional saturating performance counters are built only when
//             the macro COND_UNIT_PERF_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module cond_unit #(
    parameter int WE_W     = 3,
    parameter int PIPE_OUT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [3:0]       cond_i,
    input  logic [3:0]       alu_flags_i,
    input  logic [1:0]       flag_w_i,
    input  logic [WE_W-1:0]  we_i,
    input  logic             flags_ld_i,
    input  logic [3:0]       flags_ld_data_i,
    output logic [WE_W-1:0]  we_o,
    output logic             cond_o,
    output logic             valid_o,
    output logic [3:0]       flags_o,
    output logic [CNT_W-1:0] exec_cnt_o,
    output logic [CNT_W-1:0] squash_cnt_o
);

    logic [3:0]      r_flags;
    logic            w_n, w_z, w_c, w_v, w_ge;
    logic            w_pass;
    logic            w_accept;
    logic            w_exec;
    logic [WE_W-1:0] w_we;

    assign w_n  = r_flags[3];
    assign w_z  = r_flags[2];
    assign w_c  = r_flags[1];
    assign w_v  = r_flags[0];
    assign w_ge = (w_n == w_v);

    // Condition decode against the registered flags only (no ALU bypass)
    always_comb begin
        w_pass = 1'b0;
        case (cond_i)
            4'b0000: w_pass = w_z;
            4'b0001: w_pass = ~w_z;
            4'b0010: w_pass = w_c;
            4'b0011: w_pass = ~w_c;
            4'b0100: w_pass = w_n;
            4'b0101: w_pass = ~w_n;
            4'b0110: w_pass = w_v;
            4'b0111: w_pass = ~w_v;
            4'b1000: w_pass = w_c & ~w_z;
            4'b1001: w_pass = ~(w_c & ~w_z);
            4'b1010: w_pass = w_ge;
            4'b1011: w_pass = ~w_ge;
            4'b1100: w_pass = ~w_z & w_ge;
            4'b1101: w_pass = ~(~w_z & w_ge);
            4'b1110: w_pass = 1'b1;
            default: w_pass = 1'b0;   // 1111: never executes
        endcase
    end

    assign w_accept = valid_i & ~stall_i & ~flush_i;
    assign w_exec   = w_accept & w_pass;
    assign w_we     = we_i & {WE_W{w_exec}};
    assign flags_o  = r_flags;

    // Flag register: force-load beats instruction update; groups independent
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_flags <= 4'b0000;
        end else if (flags_ld_i) begin
            r_flags <= flags_ld_data_i;
        end else begin
            if (w_exec && flag_w_i[1]) begin
                r_flags[3:2] <= alu_flags_i[3:2];
            end
            if (w_exec && flag_w_i[0]) begin
                r_flags[1:0] <= alu_flags_i[1:0];
            end
        end
    end

    generate
        if (PIPE_OUT != 0) begin : g_pipe_out
            logic [WE_W-1:0] r_we;
            logic            r_cond;
            logic            r_valid;

            // Output stage: flush clears, stall holds, otherwise capture
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_we    <= '0;
                    r_cond  <= 1'b0;
                    r_valid <= 1'b0;
                end else if (flush_i) begin
                    r_we    <= '0;
                    r_cond  <= 1'b0;
                    r_valid <= 1'b0;
                end else if (!stall_i) begin
                    r_we    <= w_we;
                    r_cond  <= w_exec;
                    r_valid <= w_accept;
                end
            end

            assign we_o    = r_we;
            assign cond_o  = r_cond;
            assign valid_o = r_valid;
        end else begin : g_comb_out
            assign we_o    = w_we;
            assign cond_o  = w_exec;
            assign valid_o = w_accept;
        end
    endgenerate

`ifdef COND_UNIT_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    // Saturating counters of executed and condition-failed instructions
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_exec && (r_exec_cnt != c_cnt_max)) begin
                r_exec_cnt <= r_exec_cnt + c_cnt_one;
            end
            if (w_accept && !w_pass && (r_squash_cnt != c_cnt_max)) begin
                r_squash_cnt <= r_squash_cnt + c_cnt_one;
            end
        end
    end

    assign exec_cnt_o   = r_exec_cnt;
    assign squash_cnt_o = r_squash_cnt;
`else
    assign exec_cnt_o   = '0;
    assign squash_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cond_unit
//  Brief    : Directed self-checking bench for cond_unit (PIPE_OUT=1,
//             CNT_W=4). A reference model of the flag register predicts each
//             accepted instruction's gated outputs, which are queued and
//             compared when the output stage presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

    localparam int WE_W  = 3;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             valid_i, stall_i, flush_i, flags_ld_i;
    logic [3:0]       cond_i, alu_flags_i, flags_ld_data_i;
    logic [1:0]       flag_w_i;
    logic [WE_W-1:0]  we_i;
    logic [WE_W-1:0]  we_o;
    logic             cond_o, valid_o;
    logic [3:0]       flags_o;
    logic [CNT_W-1:0] exec_cnt_o, squash_cnt_o;

    cond_unit #(.WE_W(WE_W), .PIPE_OUT(1), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .cond_i         (cond_i),
        .alu_flags_i    (alu_flags_i),
        .flag_w_i       (flag_w_i),
        .we_i           (we_i),
        .flags_ld_i     (flags_ld_i),
        .flags_ld_data_i(flags_ld_data_i),
        .we_o           (we_o),
        .cond_o         (cond_o),
        .valid_o        (valid_o),
        .flags_o        (flags_o),
        .exec_cnt_o     (exec_cnt_o),
        .squash_cnt_o   (squash_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [WE_W-1:0] we;
        logic            c;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] m_flags;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference condition table
    function automatic logic m_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One cycle: drive at negedge, predict, clock, then check at next negedge
    task automatic step(input logic v, input logic st, input logic fl,
                        input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input logic [WE_W-1:0] we,
                        input logic ld, input logic [3:0] ldd);
        logic acc, ex;
        exp_t e, got;
        valid_i = v; stall_i = st; flush_i = fl; cond_i = c;
        alu_flags_i = alu; flag_w_i = fw; we_i = we;
        flags_ld_i = ld; flags_ld_data_i = ldd;
        acc = v && !st && !fl;
        ex  = acc && m_pass(c, m_flags);
        if (acc) begin
            e.we = ex ? we : '0;
            e.c  = ex;
            sb_q.push_back(e);
        end
        if (ld) begin
            m_flags = ldd;
        end else begin
            if (ex && fw[1]) m_flags[3:2] = alu[3:2];
            if (ex && fw[0]) m_flags[1:0] = alu[1:0];
        end
        @(posedge clk_i);
        @(negedge clk_i);
        chk("flags", {28'd0, flags_o}, {28'd0, m_flags});
        if (acc) begin
            chk("valid_out", {31'd0, valid_o}, 32'd1);
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e   = sb_q.pop_front();
                got = {we_o, cond_o};
                chk("we_out", {29'd0, got.we}, {29'd0, e.we});
                chk("cond_out", {31'd0, got.c}, {31'd0, e.c});
            end
        end else if (fl || !st) begin
            chk("valid_idle", {31'd0, valid_o}, 32'd0);
        end
    endtask

    task automatic load(input logic [3:0] f);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, '0, 1'b1, f);
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        #2;
        @(negedge clk_i);
        rst_i = 1'b0;
        m_flags = 4'b0000;
        sb_q.delete();
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 0; stall_i = 0; flush_i = 0; cond_i = 0;
        alu_flags_i = 0; flag_w_i = 0; we_i = 0; flags_ld_i = 0; flags_ld_data_i = 0;
        m_flags = 4'b0000;
        @(negedge clk_i);
        rst_i = 1'b0;

        // Reset state
        chk("rst_flags", {28'd0, flags_o}, 32'h0);
        chk("rst_valid", {31'd0, valid_o}, 32'h0);
        chk("rst_we", {29'd0, we_o}, 32'h0);
        chk("rst_cond", {31'd0, cond_o}, 32'h0);

        // Full condition sweep over every NZCV value
        for (int f = 0; f < 16; f++) begin
            load(f[3:0]);
            for (int c = 0; c < 16; c++) begin
                step(1'b1, 1'b0, 1'b0, c[3:0], 4'h0, 2'b00, 3'b111, 1'b0, 4'h0);
                if (c == 15) chk("never_we", {29'd0, we_o}, 32'h0);
            end
        end

        // Independent group updates
        load(4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'hE, 4'b1111, 2'b10, 3'b001, 1'b0, 4'h0);
        chk("grp_nz", {28'd0, flags_o}, 32'hC);
        step(1'b1, 1'b0, 1'b0, 4'hE, 4'b0011, 2'b01, 3'b001, 1'b0, 4'h0);
        chk("grp_cv", {28'd0, flags_o}, 32'hF);

        // Back-to-back dependency: B sees Z written by A
        load(4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'hE, 4'b0100, 2'b11, 3'b000, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'b0000, 2'b00, 3'b010, 1'b0, 4'h0);
        chk("dep_we", {29'd0, we_o}, 32'h2);

        // Force-load wins over a same-cycle instruction flag write
        step(1'b1, 1'b0, 1'b0, 4'hE, 4'b0101, 2'b11, 3'b100, 1'b1, 4'b1010);
        chk("ld_prio", {28'd0, flags_o}, 32'hA);

        // Stall holds output register and flags, then flush+stall clears
        load(4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'hE, 4'b0000, 2'b00, 3'b101, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'hE, 4'b1111, 2'b11, 3'b111, 1'b0, 4'h0);
            chk("stall_we", {29'd0, we_o}, 32'h5);
            chk("stall_valid", {31'd0, valid_o}, 32'h1);
            chk("stall_flags", {28'd0, flags_o}, 32'h0);
        end
        step(1'b1, 1'b1, 1'b1, 4'hE, 4'b1111, 2'b11, 3'b111, 1'b0, 4'h0);
        chk("flush_we", {29'd0, we_o}, 32'h0);
        chk("flush_cond", {31'd0, cond_o}, 32'h0);

        // Asynchronous reset mid-cycle with flags=1111 and a valid output
        load(4'b1111);
        step(1'b1, 1'b0, 1'b0, 4'hE, 4'b0000, 2'b00, 3'b111, 1'b0, 4'h0);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_flags", {28'd0, flags_o}, 32'h0);
        chk("arst_valid", {31'd0, valid_o}, 32'h0);
        chk("arst_we", {29'd0, we_o}, 32'h0);
        do_reset();

        // Performance counters: 20 passing, 3 failing
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 3'b001, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 2'b00, 3'b001, 1'b0, 4'h0);
`ifdef COND_UNIT_PERF_CNT_EN
        chk("exec_cnt", {28'd0, exec_cnt_o}, 32'd15);
        chk("squash_cnt", {28'd0, squash_cnt_o}, 32'd3);
`else
        chk("exec_cnt", {28'd0, exec_cnt_o}, 32'd0);
        chk("squash_cnt", {28'd0, squash_cnt_o}, 32'd0);
`endif
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, '0, 1'b0, 4'h0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
